control_unit_pipe: RTL
======================

# control_unit_pipe

Pipelined, debugger-aware successor to the combinational MIPS decode unit. It decodes `op`/`funct` in the ID stage and registers the resulting control word into the ID/EX boundary, with stall, flush and bubble insertion. A run/pause/drain/halt state machine gates instruction fetch, supports single-step debugging, and drains the pipeline after an END instruction. It sits between the IF/ID instruction register and the EX stage, and feeds `pc_enable`/`halted` to the fetch unit and the debugger UART.

## Interface
- ALUCTL_W, 4: ALU control width; codes are zero-extended from the 4-bit set below.
- MEMWR_W, 4: byte-enable width of `mem_write_e`; must be ≥2.
- DRAIN_CYCLES, 4: cycles spent in DRAIN after END is accepted; must be ≥1.
- SUPPORT_JUMP, 1: 1 decodes J/JAL/JR; 0 flags them illegal.

- clk  in  1  single clock, rising edge; one clock, reset is synchronous and active-high
- reset  in  1  synchronous, active-high
- op  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- instr_valid  in  1  IF/ID holds a real instruction
- stall  in  1  hold ID/EX contents (hazard unit)
- flush  in  1  load bubble into ID/EX (branch taken)
- step_mode  in  1  debugger single-step enable
- step_req  in  1  one-cycle pulse: release one instruction
- alu_ctrl_e  out  ALUCTL_W  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOR 0101, SLL 0110, SRL 0111, SRA 1000, SLT 1001
- reg_write_e, mem_to_reg_e, branch_e, reg_dst_e, jump_e  out  1 each
- alu_src_e  out  2  0 reg, 1 sign-imm, 2 shamt, 3 LUI constant 16
- mem_write_e  out  MEMWR_W  byte enables
- mem_read_e  out  2  0 word, 1 byte, 2 half
- illegal_e  out  1  undefined op/funct accepted (one cycle)
- pc_enable  out  1  fetch may advance
- halted  out  1  in HALT
- state  out  2  RUN 0, PAUSE 1, DRAIN 2, HALT 3

## Operation
- Decode uses the team's MIPS table:
  - R-type (op 000000): ADD, SUB, AND, OR, XOR, NOR, SLT, SLLV, SRLV, SRAV use alu_src 0; SLL, SRL, SRA use alu_src 2. All set reg_write=1, reg_dst=1.
  - Loads: LB/LBU set mem_read=1; LH/LHU set mem_read=2; LW/LWU set mem_read=0. All set reg_write=1, mem_to_reg=1, alu_src=1, ADD.
  - Stores (alu_src=1, ADD): SB writes mask 1 (bit0); SH writes bits[1:0]; SW writes all ones.
  - Immediates (alu_src=1, reg_write=1): ADDI, ANDI, ORI, XORI, SLTI. LUI uses alu_src=3, SLL.
  - BEQ/BNE: branch=1.
  - J: jump=1. JAL: jump=1, reg_write=1. JR (funct 001000): jump=1.
  - END 111111: triggers drain. FINISH 111110: bubble.
  - Any other op/funct: bubble plus illegal_e=1.
- Bubble: every control output 0, illegal_e 0.
- Accept: `instr_valid & ~stall & ~flush & (state==RUN)`. Only an accepted instruction loads its decoded word. An unaccepted cycle loads a bubble, except that stall holds the register.
- ID/EX update priority: reset > flush (bubble) > stall (hold) > accept (decode) > bubble.
- FSM:
  - RUN: pc_enable=~stall.
    - Accepted END: go to DRAIN, drain counter=DRAIN_CYCLES-1.
    - Else, accepted instruction with step_mode=1: go to PAUSE.
  - PAUSE: pc_enable=0, bubbles.
    - step_req or step_mode=0: go to RUN.
  - DRAIN: pc_enable=0, bubbles. Counter decrements each cycle; at 0, go to HALT.
  - HALT: halted=1, pc_enable=0, bubbles. Only reset exits.
- END with step_mode=1: END takes priority and goes to DRAIN.
- stall/flush are honoured in all states. flush in DRAIN does not alter the counter.

## Timing
- Reset: state=RUN, all `_e` outputs 0, halted=0, drain counter 0. pc_enable=1 on the cycle after reset deasserts. Reset is honoured mid-DRAIN/PAUSE/HALT.
- Decode latency: 1 cycle, instruction present at edge N appears on `_e` after edge N.
- pc_enable and halted are combinational from `state` and `stall`. state changes at the edge of the accepting cycle.
- END accepted at edge N: pc_enable=0 from N; halted=1 from edge N+DRAIN_CYCLES.
- Step: step_req at edge N in PAUSE gives RUN for exactly one cycle. If that cycle's instruction is accepted, state returns to PAUSE at N+1. If stalled, state stays in RUN until acceptance.
- illegal_e is high for exactly the one cycle the bubble is in ID/EX, or longer if stall holds it.

## Test plan
- Reset, then ADD (op 0, funct 100000) valid: next cycle alu_ctrl_e=0000, reg_write_e=1, reg_dst_e=1, alu_src_e=0. SLL gives alu_src_e=2, alu_ctrl_e=0110.
- SB/SH/SW with MEMWR_W=4: mem_write_e=0001/0011/1111. LH gives mem_read_e=2, mem_to_reg_e=1. LUI gives alu_src_e=3, alu_ctrl_e=0110.
- LW with stall high 3 cycles, then flush: outputs hold LW word for 3 cycles, then all zero. stall+flush together gives zeros.
- END accepted with DRAIN_CYCLES=4: pc_enable falls immediately, state=2 for 4 cycles, then halted=1. Further valid instructions give bubbles. reset returns to state=0.
- step_mode=1, ADDI accepted: state=PAUSE, pc_enable=0. step_req pulse: one ORI decoded (alu_ctrl_e=0011), then PAUSE again.
- op 010000, or op 000010 with SUPPORT_JUMP=0: all controls 0, illegal_e=1 for one cycle. Same op 000010 with SUPPORT_JUMP=1: jump_e=1.

Source files
------------

// File: rtl/control_unit_pipe_if.sv
// Bundle between the IF/ID register, hazard/debug logic and the pipelined control unit.
// The master drives instruction and hazard/debug inputs; the slave returns the EX-stage control word.
interface control_unit_pipe_if #(
   parameter int ALUCTL_W = 4,
   parameter int MEMWR_W  = 4
);
   logic [5:0]          op;
   logic [5:0]          funct;
   logic                instr_valid;
   logic                stall;
   logic                flush;
   logic                step_mode;
   logic                step_req;
   logic [ALUCTL_W-1:0] alu_ctrl_e;
   logic                reg_write_e;
   logic                mem_to_reg_e;
   logic                branch_e;
   logic                reg_dst_e;
   logic                jump_e;
   logic [1:0]          alu_src_e;
   logic [MEMWR_W-1:0]  mem_write_e;
   logic [1:0]          mem_read_e;
   logic                illegal_e;
   logic                pc_enable;
   logic                halted;
   logic [1:0]          state;

   modport master (
      output op, funct, instr_valid, stall, flush, step_mode, step_req,
      input  alu_ctrl_e, reg_write_e, mem_to_reg_e, branch_e, reg_dst_e, jump_e,
             alu_src_e, mem_write_e, mem_read_e, illegal_e, pc_enable, halted, state
   );

   modport slave (
      input  op, funct, instr_valid, stall, flush, step_mode, step_req,
      output alu_ctrl_e, reg_write_e, mem_to_reg_e, branch_e, reg_dst_e, jump_e,
             alu_src_e, mem_write_e, mem_read_e, illegal_e, pc_enable, halted, state
   );
endinterface

// File: rtl/control_unit_pipe.sv
// Pipelined MIPS control unit: ID-stage decode registered into ID/EX, with
// stall/flush handling and a run/pause/drain/halt controller for fetch and debug.
module control_unit_pipe #(
   parameter int ALUCTL_W     = 4,
   parameter int MEMWR_W      = 4,
   parameter int DRAIN_CYCLES = 4,
   parameter int SUPPORT_JUMP = 1
) (
   input logic               clk,
   input logic               reset,
   control_unit_pipe_if.slave bus
);
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_PAUSE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_NOR = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1000;
   localparam logic [3:0] ALU_SLT = 4'b1001;

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef struct packed {
      logic [ALUCTL_W-1:0] alu_ctrl;
      logic                reg_write;
      logic                mem_to_reg;
      logic                branch;
      logic                reg_dst;
      logic                jump;
      logic [1:0]          alu_src;
      logic [MEMWR_W-1:0]  mem_write;
      logic [1:0]          mem_read;
      logic                illegal;
   } ctrl_t;

   ctrl_t            dec;
   ctrl_t            idex;
   logic             is_end;
   logic             accept;
   logic [1:0]       state_q;
   logic [CNT_W-1:0] drain_cnt;

   function automatic logic [ALUCTL_W-1:0] alu_code(input logic [3:0] code);
      return ALUCTL_W'(code);
   endfunction

   assign accept = bus.instr_valid && !bus.stall && !bus.flush && (state_q == ST_RUN);

   // Combinational decode; unknown encodings collapse to a bubble carrying only the illegal flag.
   always_comb begin
      dec    = '0;
      is_end = 1'b0;
      case (bus.op)
         6'b000000: begin
            dec.reg_write = 1'b1;
            dec.reg_dst   = 1'b1;
            case (bus.funct)
               6'b100000: dec.alu_ctrl = alu_code(ALU_ADD);
               6'b100010: dec.alu_ctrl = alu_code(ALU_SUB);
               6'b100100: dec.alu_ctrl = alu_code(ALU_AND);
               6'b100101: dec.alu_ctrl = alu_code(ALU_OR);
               6'b100110: dec.alu_ctrl = alu_code(ALU_XOR);
               6'b100111: dec.alu_ctrl = alu_code(ALU_NOR);
               6'b101010: dec.alu_ctrl = alu_code(ALU_SLT);
               6'b000100: dec.alu_ctrl = alu_code(ALU_SLL);
               6'b000110: dec.alu_ctrl = alu_code(ALU_SRL);
               6'b000111: dec.alu_ctrl = alu_code(ALU_SRA);
               6'b000000: begin
                  dec.alu_ctrl = alu_code(ALU_SLL);
                  dec.alu_src  = 2'd2;
               end
               6'b000010: begin
                  dec.alu_ctrl = alu_code(ALU_SRL);
                  dec.alu_src  = 2'd2;
               end
               6'b000011: begin
                  dec.alu_ctrl = alu_code(ALU_SRA);
                  dec.alu_src  = 2'd2;
               end
               6'b001000: begin
                  dec.reg_write = 1'b0;
                  dec.reg_dst   = 1'b0;
                  if (SUPPORT_JUMP != 0) dec.jump = 1'b1;
                  else dec.illegal = 1'b1;
               end
               default: begin
                  dec         = '0;
                  dec.illegal = 1'b1;
               end
            endcase
         end
         6'b100000, 6'b100100: begin
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.alu_src    = 2'd1;
            dec.mem_read   = 2'd1;
         end
         6'b100001, 6'b100101: begin
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.alu_src    = 2'd1;
            dec.mem_read   = 2'd2;
         end
         6'b100011, 6'b100111: begin
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.alu_src    = 2'd1;
         end
         6'b101000: begin
            dec.alu_src   = 2'd1;
            dec.mem_write = MEMWR_W'(1'b1);
         end
         6'b101001: begin
            dec.alu_src   = 2'd1;
            dec.mem_write = MEMWR_W'(2'b11);
         end
         6'b101011: begin
            dec.alu_src   = 2'd1;
            dec.mem_write = '1;
         end
         6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 2'd1;
            case (bus.op)
               6'b001100: dec.alu_ctrl = alu_code(ALU_AND);
               6'b001101: dec.alu_ctrl = alu_code(ALU_OR);
               6'b001110: dec.alu_ctrl = alu_code(ALU_XOR);
               6'b001010: dec.alu_ctrl = alu_code(ALU_SLT);
               default:   dec.alu_ctrl = alu_code(ALU_ADD);
            endcase
         end
         6'b001111: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 2'd3;
            dec.alu_ctrl  = alu_code(ALU_SLL);
         end
         6'b000100, 6'b000101: dec.branch = 1'b1;
         6'b000010, 6'b000011: begin
            if (SUPPORT_JUMP != 0) begin
               dec.jump      = 1'b1;
               dec.reg_write = bus.op[0];
            end else begin
               dec.illegal = 1'b1;
            end
         end
         6'b111111: is_end = 1'b1;
         6'b111110: dec = '0;
         default:   dec.illegal = 1'b1;
      endcase
   end

   // ID/EX register: flush beats stall, and anything not accepted becomes a bubble.
   always_ff @(posedge clk) begin
      if (reset)               idex <= '0;
      else if (bus.flush)      idex <= '0;
      else if (bus.stall)      idex <= idex;
      else if (accept)         idex <= dec;
      else                     idex <= '0;
   end

   // Fetch/debug controller; DRAIN lasts DRAIN_CYCLES cycles once END is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RUN;
         drain_cnt <= '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (accept && is_end) begin
                  state_q   <= ST_DRAIN;
                  drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
               end else if (accept && bus.step_mode) begin
                  state_q <= ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (bus.step_req || !bus.step_mode) state_q <= ST_RUN;
            end
            ST_DRAIN: begin
               if (drain_cnt == '0) state_q <= ST_HALT;
               else drain_cnt <= drain_cnt - CNT_W'(1);
            end
            ST_HALT:  state_q <= ST_HALT;
            default:  state_q <= ST_RUN;
         endcase
      end
   end

   assign bus.alu_ctrl_e   = idex.alu_ctrl;
   assign bus.reg_write_e  = idex.reg_write;
   assign bus.mem_to_reg_e = idex.mem_to_reg;
   assign bus.branch_e     = idex.branch;
   assign bus.reg_dst_e    = idex.reg_dst;
   assign bus.jump_e       = idex.jump;
   assign bus.alu_src_e    = idex.alu_src;
   assign bus.mem_write_e  = idex.mem_write;
   assign bus.mem_read_e   = idex.mem_read;
   assign bus.illegal_e    = idex.illegal;
   assign bus.pc_enable    = (state_q == ST_RUN) && !bus.stall;
   assign bus.halted       = (state_q == ST_HALT);
   assign bus.state        = state_q;
endmodule
